// File: rtl/dm_row_feeder.sv
// dm_row_feeder: raster pixel stream into a circular BRAM row buffer, handing
// windows of rows to the disparity engine. Optional row prefetch: DM_PREFETCH_EN.
module dm_row_feeder #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int IMG_W    = 640,
  parameter int IMG_H    = 480,
  parameter int MAX_ROWS = 8
) (
  input  logic                        clka,
  input  logic                        reset,
  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic [DATA_W-1:0]           s_data,
  input  logic [2:0]                  window,
  output logic                        ena,
  output logic [DATA_W/8-1:0]         wea,
  output logic [ADDR_W-1:0]           addra,
  output logic [DATA_W-1:0]           dina,
  output logic                        go,
  input  logic                        done,
  output logic [$clog2(MAX_ROWS)-1:0] base_slot,
  output logic                        frame_done
);

  localparam int SLOT_W = $clog2(MAX_ROWS);
  localparam int COL_W  = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int ROW_W  = $clog2(IMG_H + 1);
  localparam int WIN_W  = 5;
  localparam int BE_W   = DATA_W / 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_GO_WAIT,
    ST_SLIDE
  } state_t;

  state_t              r_state;
  state_t              w_state_next;

  logic [COL_W-1:0]    r_col;
  logic [SLOT_W-1:0]   r_wr_slot;
  logic [ROW_W-1:0]    r_rows_in;
  logic [WIN_W-1:0]    r_win_eff;
  logic [SLOT_W-1:0]   r_base_slot;
  logic                r_pf_full;
  logic                r_s_ready;
  logic                r_go;
  logic                r_frame_done;
  logic                r_ena;
  logic [BE_W-1:0]     r_wea;
  logic [ADDR_W-1:0]   r_addra;
  logic [DATA_W-1:0]   r_dina;

  logic                w_hs;
  logic                w_frame_start;
  logic [WIN_W-1:0]    w_win_req;
  logic [WIN_W-1:0]    w_win_cur;
  logic [COL_W-1:0]    w_col_cur;
  logic [SLOT_W-1:0]   w_slot_cur;
  logic [ROW_W-1:0]    w_rows_cur;
  logic [COL_W-1:0]    w_col_next;
  logic [SLOT_W-1:0]   w_slot_next;
  logic [ROW_W-1:0]    w_rows_next;
  logic [SLOT_W-1:0]   w_slot_inc;
  logic [SLOT_W-1:0]   w_base_inc;
  logic [SLOT_W-1:0]   w_base_next;
  logic [ADDR_W-1:0]   w_addr;
  logic                w_row_last;
  logic                w_row_done;
  logic                w_win_reached;
  logic                w_rows_full;
  logic                w_done_acc;
  logic                w_pf_en;
  logic                w_pf_done;
  logic                w_pf_next;
  logic                w_fdone_next;
  logic                w_ready_next;
  logic                w_go_next;

  // Effective window: 0 means 1, capped by buffer depth and frame height.
  always_comb begin
    w_win_req = WIN_W'(window);
    if (window == 3'd0)
      w_win_req = WIN_W'(1);
    else if (32'(window) > 32'(MAX_ROWS))
      w_win_req = WIN_W'(MAX_ROWS);
    if (32'(w_win_req) > 32'(IMG_H))
      w_win_req = WIN_W'(IMG_H);
  end

  assign w_hs          = s_valid & r_s_ready;
  assign w_frame_start = (r_state == ST_IDLE);

  // In IDLE the first accepted pixel already sees cleared counters.
  assign w_col_cur  = w_frame_start ? '0 : r_col;
  assign w_slot_cur = w_frame_start ? '0 : r_wr_slot;
  assign w_rows_cur = w_frame_start ? '0 : r_rows_in;
  assign w_win_cur  = w_frame_start ? w_win_req : r_win_eff;

  assign w_row_last = (w_col_cur == COL_W'(IMG_W - 1));
  assign w_row_done = w_hs & w_row_last;
  assign w_slot_inc = (w_slot_cur == SLOT_W'(MAX_ROWS - 1)) ? '0 : w_slot_cur + SLOT_W'(1);
  assign w_base_inc = (r_base_slot == SLOT_W'(MAX_ROWS - 1)) ? '0 : r_base_slot + SLOT_W'(1);
  assign w_addr     = ADDR_W'(w_slot_cur) * ADDR_W'(IMG_W) + ADDR_W'(w_col_cur);

  always_comb begin
    w_col_next  = w_col_cur;
    w_slot_next = w_slot_cur;
    w_rows_next = w_rows_cur;
    if (w_hs) begin
      if (w_row_last) begin
        w_col_next  = '0;
        w_slot_next = w_slot_inc;
        w_rows_next = w_rows_cur + ROW_W'(1);
      end else begin
        w_col_next  = w_col_cur + COL_W'(1);
      end
    end
  end

  assign w_win_reached = w_row_done && (32'(w_rows_next) == 32'(w_win_cur));
  assign w_rows_full   = (r_rows_in == ROW_W'(IMG_H));
  assign w_done_acc    = done & r_go;
  assign w_pf_done     = r_pf_full | w_row_done;

`ifdef DM_PREFETCH_EN
  // A spare slot exists only when the window does not occupy the whole buffer.
  assign w_pf_en = (w_win_cur < WIN_W'(MAX_ROWS));
`else
  assign w_pf_en = 1'b0;
`endif

  always_comb begin
    w_state_next = r_state;
    w_base_next  = r_base_slot;
    w_pf_next    = r_pf_full;
    w_fdone_next = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_hs) begin
          w_base_next  = '0;
          w_pf_next    = 1'b0;
          w_state_next = w_win_reached ? ST_GO_WAIT : ST_FILL;
        end
      end
      ST_FILL: begin
        if (w_win_reached)
          w_state_next = ST_GO_WAIT;
      end
      ST_GO_WAIT: begin
        if (w_done_acc) begin
          if (w_pf_done) begin
            // Next row already resident: slide without leaving GO_WAIT.
            w_base_next = w_base_inc;
            w_pf_next   = 1'b0;
          end else if (w_rows_full) begin
            w_fdone_next = 1'b1;
            w_state_next = ST_IDLE;
          end else begin
            w_base_next  = w_base_inc;
            w_state_next = ST_SLIDE;
          end
        end else if (w_row_done) begin
          w_pf_next = 1'b1;
        end
      end
      ST_SLIDE: begin
        if (w_row_done)
          w_state_next = ST_GO_WAIT;
      end
      default: w_state_next = ST_IDLE;
    endcase

    case (w_state_next)
      ST_GO_WAIT: w_ready_next = w_pf_en & ~w_pf_next & (w_rows_next < ROW_W'(IMG_H));
      default:    w_ready_next = 1'b1;
    endcase

    // go trails GO_WAIT entry by a cycle so the last row write lands first.
    w_go_next = (r_state == ST_GO_WAIT) && (w_state_next == ST_GO_WAIT) && !w_done_acc;
  end

  always_ff @(posedge clka or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_col        <= '0;
      r_wr_slot    <= '0;
      r_rows_in    <= '0;
      r_win_eff    <= WIN_W'(1);
      r_base_slot  <= '0;
      r_pf_full    <= 1'b0;
      r_s_ready    <= 1'b0;
      r_go         <= 1'b0;
      r_frame_done <= 1'b0;
      r_ena        <= 1'b0;
      r_wea        <= '0;
      r_addra      <= '0;
      r_dina       <= '0;
    end else begin
      r_state      <= w_state_next;
      r_col        <= w_col_next;
      r_wr_slot    <= w_slot_next;
      r_rows_in    <= w_rows_next;
      if (w_frame_start && w_hs)
        r_win_eff  <= w_win_req;
      r_base_slot  <= w_base_next;
      r_pf_full    <= w_pf_next;
      r_s_ready    <= w_ready_next;
      r_go         <= w_go_next;
      r_frame_done <= w_fdone_next;
      r_ena        <= w_hs;
      r_wea        <= w_hs ? '1 : '0;
      if (w_hs) begin
        r_addra    <= w_addr;
        r_dina     <= s_data;
      end
    end
  end

  assign s_ready    = r_s_ready;
  assign ena        = r_ena;
  assign wea        = r_wea;
  assign addra      = r_addra;
  assign dina       = r_dina;
  assign go         = r_go;
  assign base_slot  = r_base_slot;
  assign frame_done = r_frame_done;

endmodule
